// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: tracks in-flight producers in a short tag pipeline and,
// for every source operand of the instruction leaving decode, selects the
// youngest in-flight producer to forward from, or stalls decode when that
// producer is a load whose data is not yet available.
//
// Handshake: an instruction is accepted into entry 0 (EX) on a rising edge
// only when issue_valid=1, stall=0 and flush=0; while stall=1 the instruction
// stays presented at decode and a bubble enters entry 0 instead.
module hazard_fwd_unit #(
  parameter int ADDR_W     = 4,
  parameter int NUM_SRC    = 3,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 1,
  parameter int NOFWD_ADDR = 15,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       issue_valid,
  input  logic                       issue_wr,
  input  logic                       issue_load,
  input  logic [ADDR_W-1:0]          issue_dst,
  input  logic [NUM_SRC*ADDR_W-1:0]  src_addr,
  input  logic [NUM_SRC-1:0]         src_rd,
  input  logic                       flush,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       stall,
  output logic [15:0]                stall_count
);

  localparam logic [ADDR_W-1:0] NOFWD = ADDR_W'(NOFWD_ADDR);

  // Tag pipeline: index 0 is EX (youngest), DEPTH-1 is the oldest tracked.
  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_wr;
  logic [DEPTH-1:0]  ent_load;
  logic [ADDR_W-1:0] ent_dst [DEPTH];

  logic [SEL_W-1:0]   raw_sel [NUM_SRC];
  logic [NUM_SRC-1:0] use_hazard;
  logic [ADDR_W-1:0]  src_i;

  // Per-operand youngest-match search; scanning oldest to youngest lets the
  // last hit (the youngest producer) overwrite any older one.
  always_comb begin
    src_i      = '0;
    use_hazard = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      raw_sel[i] = '0;
      src_i      = src_addr[i*ADDR_W +: ADDR_W];
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent_valid[k] && ent_wr[k] && src_rd[i] &&
            (ent_dst[k] == src_i) && (src_i != NOFWD)) begin
          raw_sel[i]    = SEL_W'(k + 1);
          use_hazard[i] = ent_load[k] && (k < LOAD_LAT);
        end
      end
    end
  end

  // Stall only for a real issue attempt that is not being flushed.
  always_comb begin
    stall = issue_valid && !flush && (|use_hazard);
  end

  // Forwarding selects are suppressed while decode is held.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_sel[i*SEL_W +: SEL_W] = stall ? '0 : raw_sel[i];
    end
  end

  // Advance the tag pipeline every cycle; entry 0 takes the accepted
  // instruction or a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_valid <= '0;
      ent_wr    <= '0;
      ent_load  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        ent_dst[k] <= '0;
      end
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_wr[k]    <= ent_wr[k-1];
        ent_load[k]  <= ent_load[k-1];
        ent_dst[k]   <= ent_dst[k-1];
      end
      ent_valid[0] <= issue_valid && !stall && !flush;
      ent_wr[0]    <= issue_wr;
      ent_load[0]  <= issue_load;
      ent_dst[0]   <= issue_dst;
    end
  end

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed scenarios plus a randomized run against a
// history-based reference model, and a saturation run on a deep-pipeline
// instance where almost every cycle stalls.
module tb_hazard_fwd_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- main DUT (default parameters) ----------------
  logic        reset_n;
  logic        issue_valid, issue_wr, issue_load, flush;
  logic [3:0]  issue_dst;
  logic [11:0] src_addr;
  logic [2:0]  src_rd;
  logic [5:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_count;

  hazard_fwd_unit dut (
    .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid),
    .issue_wr(issue_wr), .issue_load(issue_load), .issue_dst(issue_dst),
    .src_addr(src_addr), .src_rd(src_rd), .flush(flush),
    .fwd_sel(fwd_sel), .stall(stall), .stall_count(stall_count)
  );

  // ---------------- deep instance for saturation ----------------
  logic        s_reset_n = 1'b0;
  logic        s_valid = 1'b1, s_wr = 1'b1, s_load = 1'b1, s_flush = 1'b0;
  logic [3:0]  s_dst = 4'd5;
  logic [3:0]  s_src = 4'd5;
  logic [0:0]  s_rd = 1'b1;
  logic [5:0]  s_fwd_sel;
  logic        s_stall;
  logic [15:0] s_count;

  hazard_fwd_unit #(.ADDR_W(4), .NUM_SRC(1), .DEPTH(32), .LOAD_LAT(31),
                    .NOFWD_ADDR(15)) sat (
    .clk(clk), .reset_n(s_reset_n), .issue_valid(s_valid),
    .issue_wr(s_wr), .issue_load(s_load), .issue_dst(s_dst),
    .src_addr(s_src), .src_rd(s_rd), .flush(s_flush),
    .fwd_sel(s_fwd_sel), .stall(s_stall), .stall_count(s_count)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_wr = 1'b0; issue_load = 1'b0;
    issue_dst = 4'd0; src_addr = 12'd0; src_rd = 3'd0; flush = 1'b0;
  endtask

  task automatic drive_issue(input logic wr, input logic ld, input logic [3:0] dst);
    issue_valid = 1'b1; issue_wr = wr; issue_load = ld; issue_dst = dst;
  endtask

  task automatic drive_src(input logic [3:0] a0, input logic [3:0] a1,
                           input logic [3:0] a2, input logic [2:0] rd);
    src_addr = {a2, a1, a0};
    src_rd   = rd;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    reset_n = 1'b0;
    #2;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", stall); end
    total++;
    if (fwd_sel !== 6'd0) begin bad++; $display("FAIL reset_fwd got=%0h want=0", fwd_sel); end
    total++;
    if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", stall_count); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_issue(1'b1, 1'b0, 4'd3); drive_src(4'd0, 4'd0, 4'd0, 3'b000);
    tick();
    drive_issue(1'b0, 1'b0, 4'd0); drive_src(4'd3, 4'd0, 4'd0, 3'b001);
    @(negedge clk);
    total++;
    if (fwd_sel !== 6'b00_00_01 || stall !== 1'b0) begin
      bad++; $display("FAIL b2b_dist1 got sel=%0h stall=%0b want sel=01 stall=0", fwd_sel, stall);
    end
    tick();
    drive_src(4'd0, 4'd3, 4'd0, 3'b010);
    @(negedge clk);
    total++;
    if (fwd_sel !== 6'b00_10_00) begin
      bad++; $display("FAIL b2b_dist2 got sel=%0h want=08", fwd_sel);
    end
    tick();
    drain();
  endtask

  task automatic test_load_use();
    do_reset();
    drive_issue(1'b1, 1'b1, 4'd5); drive_src(4'd0, 4'd0, 4'd0, 3'b000);
    tick();
    drive_issue(1'b0, 1'b0, 4'd0); drive_src(4'd5, 4'd0, 4'd0, 3'b001);
    @(negedge clk);
    total++;
    if (stall !== 1'b1 || fwd_sel !== 6'd0 || stall_count !== 16'd0) begin
      bad++; $display("FAIL lu_stall got stall=%0b sel=%0h cnt=%0d want 1/0/0", stall, fwd_sel, stall_count);
    end
    tick();
    @(negedge clk);
    total++;
    if (stall !== 1'b0 || fwd_sel !== 6'b00_00_10 || stall_count !== 16'd1) begin
      bad++; $display("FAIL lu_release got stall=%0b sel=%0h cnt=%0d want 0/02/1", stall, fwd_sel, stall_count);
    end
    tick();
    drain();
  endtask

  task automatic test_youngest();
    do_reset();
    drive_issue(1'b1, 1'b0, 4'd2); drive_src(4'd0, 4'd0, 4'd0, 3'b000);
    tick();
    tick();
    drive_issue(1'b0, 1'b0, 4'd0); drive_src(4'd2, 4'd2, 4'd2, 3'b101);
    @(negedge clk);
    total++;
    if (fwd_sel !== 6'b01_00_01 || stall !== 1'b0) begin
      bad++; $display("FAIL youngest got sel=%0h stall=%0b want sel=11 stall=0", fwd_sel, stall);
    end
    tick();
    drain();
  endtask

  task automatic test_pc_retire();
    do_reset();
    drive_issue(1'b1, 1'b1, 4'd15); drive_src(4'd0, 4'd0, 4'd0, 3'b000);
    tick();
    drive_issue(1'b0, 1'b0, 4'd0); drive_src(4'd15, 4'd0, 4'd0, 3'b001);
    @(negedge clk);
    total++;
    if (fwd_sel !== 6'd0 || stall !== 1'b0) begin
      bad++; $display("FAIL pc_nofwd got sel=%0h stall=%0b want 0/0", fwd_sel, stall);
    end
    tick();
    // oldest stage still forwards
    drain();
    drive_issue(1'b1, 1'b0, 4'd4); drive_src(4'd0, 4'd0, 4'd0, 3'b000);
    tick();
    idle(); tick(); tick();
    drive_issue(1'b0, 1'b0, 4'd0); drive_src(4'd4, 4'd0, 4'd0, 3'b001);
    @(negedge clk);
    total++;
    if (fwd_sel !== 6'b00_00_11) begin
      bad++; $display("FAIL oldest_stage got sel=%0h want=03", fwd_sel);
    end
    tick();
    // retired after three idle cycles
    drain();
    drive_issue(1'b1, 1'b0, 4'd4); drive_src(4'd0, 4'd0, 4'd0, 3'b000);
    tick();
    idle(); tick(); tick(); tick();
    drive_issue(1'b0, 1'b0, 4'd0); drive_src(4'd4, 4'd0, 4'd0, 3'b001);
    @(negedge clk);
    total++;
    if (fwd_sel !== 6'd0) begin
      bad++; $display("FAIL retired got sel=%0h want=0", fwd_sel);
    end
    tick();
    drain();
  endtask

  task automatic test_flush();
    do_reset();
    drive_issue(1'b1, 1'b1, 4'd6); drive_src(4'd0, 4'd0, 4'd0, 3'b000); flush = 1'b1;
    tick();
    flush = 1'b0;
    drive_issue(1'b0, 1'b0, 4'd0); drive_src(4'd6, 4'd0, 4'd0, 3'b001);
    @(negedge clk);
    total++;
    if (fwd_sel !== 6'd0 || stall !== 1'b0) begin
      bad++; $display("FAIL flush_drop got sel=%0h stall=%0b want 0/0", fwd_sel, stall);
    end
    tick();
    drain();
    // flush on the consumer cycle overrides the load-use stall
    drive_issue(1'b1, 1'b1, 4'd7); drive_src(4'd0, 4'd0, 4'd0, 3'b000);
    tick();
    drive_issue(1'b0, 1'b0, 4'd0); drive_src(4'd7, 4'd0, 4'd0, 3'b001); flush = 1'b1;
    @(negedge clk);
    total++;
    if (stall !== 1'b0 || stall_count !== 16'd0) begin
      bad++; $display("FAIL flush_nostall got stall=%0b cnt=%0d want 0/0", stall, stall_count);
    end
    tick();
    drain();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    // a load that reads its own destination stalls every other cycle
    drive_issue(1'b1, 1'b1, 4'd5); drive_src(4'd5, 4'd0, 4'd0, 3'b001);
    tick(); tick(); tick();
    @(negedge clk);
    total++;
    if (stall !== 1'b1 || stall_count !== 16'd1) begin
      bad++; $display("FAIL pre_reset got stall=%0b cnt=%0d want 1/1", stall, stall_count);
    end
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (stall !== 1'b0 || stall_count !== 16'd0 || fwd_sel !== 6'd0) begin
      bad++; $display("FAIL mid_stall_reset got stall=%0b cnt=%0d sel=%0h want 0/0/0", stall, stall_count, fwd_sel);
    end
    idle();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // ---------------- randomized run with reference model ----------------
  typedef struct {
    logic       v;
    logic       w;
    logic       l;
    logic [3:0] d;
  } tag_t;

  function automatic logic [3:0] pick_addr();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 4'd15 : 4'(r);
  endfunction

  task automatic test_random();
    tag_t       hist[$];
    tag_t       t;
    logic [5:0] exp_q[$];
    logic [5:0] exp_sel;
    logic       exp_stall;
    int         cnt_m;
    logic [3:0] a;
    do_reset();
    hist.delete();
    for (int k = 0; k < 3; k++) begin
      t.v = 1'b0; t.w = 1'b0; t.l = 1'b0; t.d = 4'd0;
      hist.push_back(t);
    end
    cnt_m = 0;
    for (int c = 0; c < 400; c++) begin
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_wr    = ($urandom_range(0, 3) != 0);
      issue_load  = ($urandom_range(0, 2) == 0);
      issue_dst   = pick_addr();
      src_addr    = {pick_addr(), pick_addr(), pick_addr()};
      src_rd      = 3'($urandom_range(0, 7));
      flush       = ($urandom_range(0, 9) == 0);
      // model: youngest writer of each operand in the last three issue slots
      exp_sel   = '0;
      exp_stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
        a = src_addr[i*4 +: 4];
        if (src_rd[i] && a != 4'd15) begin
          for (int j = 0; j < 3; j++) begin
            if (hist[j].v && hist[j].w && hist[j].d == a) begin
              exp_sel[i*2 +: 2] = 2'(j + 1);
              if (hist[j].l && j < 1 && issue_valid && !flush) exp_stall = 1'b1;
              break;
            end
          end
        end
      end
      if (exp_stall) exp_sel = '0;
      exp_q.push_back(exp_sel);
      @(negedge clk);
      exp_sel = exp_q.pop_front();
      total++;
      if (fwd_sel !== exp_sel || stall !== exp_stall || stall_count !== 16'(cnt_m)) begin
        bad++;
        $display("FAIL rand_cycle%0d got sel=%0h stall=%0b cnt=%0d want sel=%0h stall=%0b cnt=%0d",
                 c, fwd_sel, stall, stall_count, exp_sel, exp_stall, cnt_m);
      end
      t.v = issue_valid && !exp_stall && !flush;
      t.w = issue_wr; t.l = issue_load; t.d = issue_dst;
      hist.push_front(t);
      void'(hist.pop_back());
      if (exp_stall) cnt_m++;
      tick();
    end
    drain();
  endtask

  // ---------------- saturation on the deep instance ----------------
  // With a self-dependent load always presented, the load issues on every
  // 32nd cycle and the 31 cycles in between stall.
  task automatic test_saturation();
    int   cnt_m;
    logic exp_stall;
    s_reset_n = 1'b1;
    cnt_m = 0;
    for (int c = 0; c < 67700; c++) begin
      exp_stall = ((c % 32) != 0);
      @(negedge clk);
      if ((c % 997) == 0 || c == 67699) begin
        total++;
        if (s_stall !== exp_stall || s_count !== 16'(cnt_m)) begin
          bad++;
          $display("FAIL sat_cycle%0d got stall=%0b cnt=%0d want stall=%0b cnt=%0d",
                   c, s_stall, s_count, exp_stall, cnt_m);
        end
      end
      if (c == 64) begin
        total++;
        if (s_fwd_sel !== 6'd32) begin
          bad++; $display("FAIL sat_fwd_oldest got=%0d want=32", s_fwd_sel);
        end
      end
      if (exp_stall && cnt_m < 65535) cnt_m++;
      tick();
    end
    total++;
    if (s_count !== 16'hFFFF) begin
      bad++; $display("FAIL sat_final got=%0h want=ffff", s_count);
    end
    s_reset_n = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle();
    reset_n = 1'b0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_youngest();
    test_pc_retire();
    test_flush();
    test_reset_mid_stall();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
